// File: rtl/decode_stage.sv
// RV32I decode stage: turns a fetched PC/instruction into registered operand,
// immediate, class and ALU-op fields for execute, with a load-use interlock.
module decode_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         i_pc,
  input  logic [31:0]         i_instr,
  input  logic                i_clk_en,
  input  logic                i_stall,
  input  logic                i_flush,
  output logic                o_stall_req,
  output logic                o_clk_en,
  output logic [31:0]         o_pc,
  output logic [4:0]          o_rs1_addr,
  output logic [4:0]          o_rs2_addr,
  output logic [4:0]          o_rd_addr,
  output logic [31:0]         o_imm,
  output logic [2:0]          o_funct3,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [10:0]         o_class,
  output logic                o_illegal,
  output logic                o_ecall,
  output logic                o_ebreak,
  output logic                o_mret
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam int C_RTYPE  = 0;
  localparam int C_ITYPE  = 1;
  localparam int C_LOAD   = 2;
  localparam int C_STORE  = 3;
  localparam int C_BRANCH = 4;
  localparam int C_JAL    = 5;
  localparam int C_JALR   = 6;
  localparam int C_LUI    = 7;
  localparam int C_AUIPC  = 8;
  localparam int C_SYSTEM = 9;
  localparam int C_FENCE  = 10;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_LT   = 4'd12;
  localparam logic [3:0] ALU_GE   = 4'd13;
  localparam logic [3:0] ALU_LTU  = 4'd14;
  localparam logic [3:0] ALU_GEU  = 4'd15;

  localparam logic [6:0]  F7_ZERO = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;
  localparam logic [31:0] I_ECALL  = 32'h0000_0073;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_MRET   = 32'h3020_0073;

  typedef struct packed {
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    logic [2:0]          funct3;
    logic [ALU_OP_W-1:0] alu_op;
    logic [10:0]         cls;
    logic                illegal;
    logic                ecall;
    logic                ebreak;
    logic                mret;
  } dec_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [10:0] cls_raw;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic [3:0]  alu_rr, alu_br, alu_sel;
  logic        is_ecall, is_ebreak, is_mret, ill;
  logic        uses_rs1, uses_rs2, stall_req;
  dec_t        dec, dec_q, dec_d;
  logic        clk_en_q, clk_en_d;
  logic [31:0] pc_q, pc_d;

  assign opc = i_instr[6:0];
  assign f3  = i_instr[14:12];
  assign f7  = i_instr[31:25];

  always_comb begin
    cls_raw = '0;
    case (opc)
      OPC_OP:     cls_raw[C_RTYPE]  = 1'b1;
      OPC_OP_IMM: cls_raw[C_ITYPE]  = 1'b1;
      OPC_LOAD:   cls_raw[C_LOAD]   = 1'b1;
      OPC_STORE:  cls_raw[C_STORE]  = 1'b1;
      OPC_BRANCH: cls_raw[C_BRANCH] = 1'b1;
      OPC_JAL:    cls_raw[C_JAL]    = 1'b1;
      OPC_JALR:   cls_raw[C_JALR]   = 1'b1;
      OPC_LUI:    cls_raw[C_LUI]    = 1'b1;
      OPC_AUIPC:  cls_raw[C_AUIPC]  = 1'b1;
      OPC_SYSTEM: cls_raw[C_SYSTEM] = 1'b1;
      OPC_FENCE:  cls_raw[C_FENCE]  = 1'b1;
      default:    cls_raw = '0;
    endcase
  end

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                  i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                  i_instr[30:21], 1'b0};

  // Immediate format follows the opcode even when the encoding is illegal.
  always_comb begin
    imm_sel = '0;
    if (cls_raw[C_ITYPE] | cls_raw[C_LOAD] | cls_raw[C_JALR] |
        cls_raw[C_SYSTEM] | cls_raw[C_FENCE])    imm_sel = imm_i;
    else if (cls_raw[C_STORE])                   imm_sel = imm_s;
    else if (cls_raw[C_BRANCH])                  imm_sel = imm_b;
    else if (cls_raw[C_LUI] | cls_raw[C_AUIPC])  imm_sel = imm_u;
    else if (cls_raw[C_JAL])                     imm_sel = imm_j;
  end

  always_comb begin
    alu_rr = ALU_ADD;
    case (f3)
      3'b000: alu_rr = (cls_raw[C_RTYPE] && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b001: alu_rr = ALU_SLL;
      3'b010: alu_rr = ALU_SLT;
      3'b011: alu_rr = ALU_SLTU;
      3'b100: alu_rr = ALU_XOR;
      3'b101: alu_rr = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      3'b110: alu_rr = ALU_OR;
      3'b111: alu_rr = ALU_AND;
      default: alu_rr = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_br = ALU_ADD;
    case (f3)
      3'b000: alu_br = ALU_EQ;
      3'b001: alu_br = ALU_NE;
      3'b100: alu_br = ALU_LT;
      3'b101: alu_br = ALU_GE;
      3'b110: alu_br = ALU_LTU;
      3'b111: alu_br = ALU_GEU;
      default: alu_br = ALU_ADD;
    endcase
  end

  assign is_ecall  = (i_instr == I_ECALL);
  assign is_ebreak = (i_instr == I_EBREAK);
  assign is_mret   = (i_instr == I_MRET);

  always_comb begin
    ill = ~|cls_raw;
    if (cls_raw[C_RTYPE])
      ill = !((f7 == F7_ZERO) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
    else if (cls_raw[C_ITYPE])
      ill = (f3 == 3'b001 && f7 != F7_ZERO) ||
            (f3 == 3'b101 && f7 != F7_ZERO && f7 != F7_ALT);
    else if (cls_raw[C_BRANCH])
      ill = (f3 == 3'b010) || (f3 == 3'b011);
    else if (cls_raw[C_LOAD])
      ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else if (cls_raw[C_STORE])
      ill = (f3 > 3'b010);
    else if (cls_raw[C_JALR])
      ill = (f3 != 3'b000);
    else if (cls_raw[C_SYSTEM])
      ill = (f3 == 3'b000) && !(is_ecall || is_ebreak || is_mret);
  end

  always_comb begin
    alu_sel = ALU_ADD;
    if (cls_raw[C_RTYPE] | cls_raw[C_ITYPE]) alu_sel = alu_rr;
    else if (cls_raw[C_BRANCH])             alu_sel = alu_br;
  end

  always_comb begin
    dec         = '0;
    dec.rs1     = i_instr[19:15];
    dec.rs2     = i_instr[24:20];
    dec.rd      = i_instr[11:7];
    dec.imm     = imm_sel;
    dec.funct3  = f3;
    dec.alu_op  = ill ? ALU_OP_W'(ALU_ADD) : ALU_OP_W'(alu_sel);
    dec.cls     = ill ? 11'b0 : cls_raw;
    dec.illegal = ill;
    dec.ecall   = is_ecall;
    dec.ebreak  = is_ebreak;
    dec.mret    = is_mret;
  end

  // Load-use interlock: compare incoming sources against the load in execute.
  assign uses_rs1 = |(dec.cls & 11'b00001011111);
  assign uses_rs2 = |(dec.cls & 11'b00000011001);
  assign stall_req = clk_en_q & dec_q.cls[C_LOAD] & (dec_q.rd != 5'd0) & i_clk_en &
                     ((uses_rs1 & (dec.rs1 == dec_q.rd)) |
                      (uses_rs2 & (dec.rs2 == dec_q.rd)));

  always_comb begin
    clk_en_d = clk_en_q;
    pc_d     = pc_q;
    dec_d    = dec_q;
    if (!i_stall) begin
      if (i_flush || stall_req) begin
        clk_en_d = 1'b0;
      end else begin
        clk_en_d = i_clk_en;
        if (i_clk_en) begin
          pc_d  = i_pc;
          dec_d = dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_en_q <= 1'b0;
      pc_q     <= PC_RESET;
      dec_q    <= '0;
    end else begin
      clk_en_q <= clk_en_d;
      pc_q     <= pc_d;
      dec_q    <= dec_d;
    end
  end

  assign o_stall_req = stall_req;
  assign o_clk_en    = clk_en_q;
  assign o_pc        = pc_q;
  assign o_rs1_addr  = dec_q.rs1;
  assign o_rs2_addr  = dec_q.rs2;
  assign o_rd_addr   = dec_q.rd;
  assign o_imm       = dec_q.imm;
  assign o_funct3    = dec_q.funct3;
  assign o_alu_op    = dec_q.alu_op;
  assign o_class     = dec_q.cls;
  assign o_illegal   = dec_q.illegal;
  assign o_ecall     = dec_q.ecall;
  assign o_ebreak    = dec_q.ebreak;
  assign o_mret      = dec_q.mret;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal checks plus randomized traffic
// compared every cycle against an instruction-level reference model.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_pc, i_instr;
  logic        i_clk_en, i_stall, i_flush;
  logic        o_stall_req, o_clk_en;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [2:0]  o_funct3;
  logic [3:0]  o_alu_op;
  logic [10:0] o_class;
  logic        o_illegal, o_ecall, o_ebreak, o_mret;

  always #5 clk = ~clk;

  decode_stage #(.PC_RESET(32'h0), .ALU_OP_W(4)) dut (
    .clk(clk), .rst(rst), .i_pc(i_pc), .i_instr(i_instr), .i_clk_en(i_clk_en),
    .i_stall(i_stall), .i_flush(i_flush), .o_stall_req(o_stall_req),
    .o_clk_en(o_clk_en), .o_pc(o_pc), .o_rs1_addr(o_rs1_addr),
    .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr), .o_imm(o_imm),
    .o_funct3(o_funct3), .o_alu_op(o_alu_op), .o_class(o_class),
    .o_illegal(o_illegal), .o_ecall(o_ecall), .o_ebreak(o_ebreak), .o_mret(o_mret)
  );

  int vectors = 0, miscompares = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [10:0] cls;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        ill, ec, eb, mr;
  } ref_t;

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  // Instruction-level reference: class index k is the bit position in o_class.
  function automatic ref_t ref_dec(input logic [31:0] ins);
    ref_t r;
    int op, f3, f7, k;
    int rr_op[8];
    int br_op[8];
    rr_op = '{0, 2, 3, 4, 5, 6, 8, 9};
    br_op = '{10, 11, 0, 0, 12, 13, 14, 15};
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    r = '0;
    case (op)
      'h33: k = 0;  'h13: k = 1;  'h03: k = 2;  'h23: k = 3;
      'h63: k = 4;  'h6F: k = 5;  'h67: k = 6;  'h37: k = 7;
      'h17: k = 8;  'h73: k = 9;  'h0F: k = 10;
      default: k = -1;
    endcase
    case (k)
      1, 2, 6, 9, 10: r.imm = 32'(sext(int'(ins[31:20]), 12));
      3: r.imm = 32'(sext(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12));
      4: r.imm = 32'(sext(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
                          int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13));
      5: r.imm = 32'(sext(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) +
                          int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2, 21));
      7, 8: r.imm = ins & 32'hFFFF_F000;
      default: r.imm = 32'h0;
    endcase
    if (k == 0 || k == 1) begin
      r.alu = 4'(rr_op[f3]);
      if (f3 == 5 && f7 == 32) r.alu = 4'd7;
      if (k == 0 && f3 == 0 && f7 == 32) r.alu = 4'd1;
    end else if (k == 4) r.alu = 4'(br_op[f3]);
    r.ec = (ins == 32'h0000_0073);
    r.eb = (ins == 32'h0010_0073);
    r.mr = (ins == 32'h3020_0073);
    case (k)
      -1: r.ill = 1'b1;
      0:  r.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      1:  r.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 32));
      2:  r.ill = (f3 == 3 || f3 == 6 || f3 == 7);
      3:  r.ill = (f3 > 2);
      4:  r.ill = (f3 == 2 || f3 == 3);
      6:  r.ill = (f3 != 0);
      9:  r.ill = (f3 == 0) && !(r.ec || r.eb || r.mr);
      default: r.ill = 1'b0;
    endcase
    if (r.ill) begin
      r.cls = '0;
      r.alu = 4'd0;
    end else r.cls = 11'(1 << k);
    return r;
  endfunction

  // Pipeline model: what execute currently holds.
  logic        m_en;
  logic [31:0] m_pc, m_ins;
  ref_t        m_d;

  function automatic bit m_hazard();
    ref_t nx;
    logic [4:0] rd;
    nx = ref_dec(i_instr);
    rd = m_ins[11:7];
    if (!(m_en && m_d.cls[2] && rd != 5'd0 && i_clk_en)) return 1'b0;
    return (((nx.cls & 11'h05F) != 0) && i_instr[19:15] == rd) ||
           (((nx.cls & 11'h019) != 0) && i_instr[24:20] == rd);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_en <= 1'b0; m_pc <= 32'h0; m_ins <= 32'h0; m_d <= '0;
    end else if (i_stall) begin
      m_en <= m_en;
    end else if (i_flush || m_hazard()) begin
      m_en <= 1'b0;
    end else begin
      m_en <= i_clk_en;
      if (i_clk_en) begin
        m_pc <= i_pc; m_ins <= i_instr; m_d <= ref_dec(i_instr);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("clk_en", 32'(o_clk_en), 32'(m_en));
      chk("pc", o_pc, m_pc);
      chk("rs1", 32'(o_rs1_addr), 32'(m_ins[19:15]));
      chk("rs2", 32'(o_rs2_addr), 32'(m_ins[24:20]));
      chk("rd", 32'(o_rd_addr), 32'(m_ins[11:7]));
      chk("funct3", 32'(o_funct3), 32'(m_ins[14:12]));
      chk("imm", o_imm, m_d.imm);
      chk("alu_op", 32'(o_alu_op), 32'(m_d.alu));
      chk("class", 32'(o_class), 32'(m_d.cls));
      chk("illegal", 32'(o_illegal), 32'(m_d.ill));
      chk("ecall", 32'(o_ecall), 32'(m_d.ec));
      chk("ebreak", 32'(o_ebreak), 32'(m_d.eb));
      chk("mret", 32'(o_mret), 32'(m_d.mr));
      chk("stall_req", 32'(o_stall_req), 32'(m_hazard()));
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic en, input logic st, input logic fl);
    i_instr = ins; i_pc = pc; i_clk_en = en; i_stall = st; i_flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [6:0]  ops[11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                           7'h37, 7'h17, 7'h73, 7'h0F};
  logic [31:0] sys_ins[3] = '{32'h0000_0073, 32'h0010_0073, 32'h3020_0073};

  initial begin
    logic [31:0] ins;
    int sel;
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_on = 1'b1;
    chk("rst_clk_en", 32'(o_clk_en), 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_imm", o_imm, 32'h0);
    chk("rst_class", 32'(o_class), 32'h0);
    chk("rst_illegal", 32'(o_illegal), 32'h0);
    rst = 1'b0;

    // Reference model pinned against hand-derived literals.
    chk("model_beq_imm", ref_dec(32'hFE00_08E3).imm, 32'hFFFF_FFF0);
    chk("model_jal_imm", ref_dec(32'h8000_006F).imm, 32'hFFF0_0000);
    chk("model_sra_alu", 32'(ref_dec(32'h4000_5033).alu), 32'd7);

    drive(32'hFFF0_0093, 32'h100, 1'b1, 1'b0, 1'b0); tick();
    chk("addi_clk_en", 32'(o_clk_en), 32'h1);
    chk("addi_pc", o_pc, 32'h100);
    chk("addi_imm", o_imm, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(o_rd_addr), 32'd1);
    chk("addi_class", 32'(o_class), 32'h002);
    chk("addi_alu", 32'(o_alu_op), 32'd0);

    drive(32'h0011_2023, 32'h104, 1'b1, 1'b0, 1'b0); tick();
    chk("sw_class", 32'(o_class), 32'h008);
    chk("sw_imm", o_imm, 32'h0);
    drive(32'hFE00_08E3, 32'h108, 1'b1, 1'b0, 1'b0); tick();
    chk("beq_imm", o_imm, 32'hFFFF_FFF0);
    chk("beq_alu", 32'(o_alu_op), 32'd10);
    chk("beq_class", 32'(o_class), 32'h010);

    drive(32'h0000_A283, 32'h10C, 1'b1, 1'b0, 1'b0); tick();
    chk("lw_class", 32'(o_class), 32'h004);
    drive(32'h0052_8333, 32'h110, 1'b1, 1'b0, 1'b0); #1;
    chk("lu_stall_req", 32'(o_stall_req), 32'h1);
    tick();
    chk("lu_bubble", 32'(o_clk_en), 32'h0);
    chk("lu_pc_held", o_pc, 32'h10C);
    chk("lu_stall_drop", 32'(o_stall_req), 32'h0);
    tick();
    chk("lu_issue", 32'(o_clk_en), 32'h1);
    chk("lu_issue_pc", o_pc, 32'h110);
    chk("lu_issue_rd", 32'(o_rd_addr), 32'd6);
    chk("lu_issue_class", 32'(o_class), 32'h001);

    drive(32'h0000_A003, 32'h114, 1'b1, 1'b0, 1'b0); tick();
    drive(32'h0000_0333, 32'h118, 1'b1, 1'b0, 1'b0); #1;
    chk("x0_no_stall", 32'(o_stall_req), 32'h0);
    tick();
    chk("x0_issue", 32'(o_clk_en), 32'h1);
    chk("x0_pc", o_pc, 32'h118);

    drive(32'h0010_0093, 32'h200, 1'b1, 1'b1, 1'b0); tick();
    chk("stall1_pc", o_pc, 32'h118);
    drive(32'h0020_0113, 32'h204, 1'b1, 1'b1, 1'b0); tick();
    chk("stall2_pc", o_pc, 32'h118);
    drive(32'hFFF0_0193, 32'h208, 1'b1, 1'b1, 1'b0); tick();
    chk("stall3_rd", 32'(o_rd_addr), 32'd6);
    chk("stall3_clk_en", 32'(o_clk_en), 32'h1);
    drive(32'h0030_0193, 32'h20C, 1'b1, 1'b0, 1'b1); tick();
    chk("flush_clk_en", 32'(o_clk_en), 32'h0);
    chk("flush_pc_hold", o_pc, 32'h118);

    drive(32'h0000_007F, 32'h300, 1'b1, 1'b0, 1'b0); tick();
    chk("ill_opc", 32'(o_illegal), 32'h1);
    chk("ill_opc_class", 32'(o_class), 32'h0);
    drive(32'h4000_1033, 32'h304, 1'b1, 1'b0, 1'b0); tick();
    chk("ill_f7", 32'(o_illegal), 32'h1);
    chk("ill_f7_alu", 32'(o_alu_op), 32'd0);
    drive(32'h0010_0073, 32'h308, 1'b1, 1'b0, 1'b0); tick();
    chk("ebreak", 32'(o_ebreak), 32'h1);
    chk("ebreak_legal", 32'(o_illegal), 32'h0);
    chk("ebreak_class", 32'(o_class), 32'h200);

    drive(32'h0052_8333, 32'h400, 1'b1, 1'b0, 1'b0); tick();
    rst = 1'b1;
    drive(32'h0000_0013, 32'h404, 1'b1, 1'b1, 1'b0); tick();
    chk("mrst_clk_en", 32'(o_clk_en), 32'h0);
    chk("mrst_pc", o_pc, 32'h0);
    chk("mrst_rd", 32'(o_rd_addr), 32'h0);
    chk("mrst_class", 32'(o_class), 32'h0);
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      sel = $urandom_range(0, 12);
      if (sel < 11) ins[6:0] = ops[sel];
      if ($urandom_range(0, 1) == 1) begin
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1)
        ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (sel == 12) ins = sys_ins[$urandom_range(0, 2)];
      rst = ($urandom_range(0, 99) == 0);
      drive(ins, $urandom, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage.
- Consumes the fetched PC and 32-bit instruction qualified by the fetch clock-enable.
- Decodes RV32I fields, generates the sign-extended immediate, classifies the instruction and flags illegal/system instructions.
- Registers all results for the execute stage.
- Detects load-use hazards against the instruction currently in execute and inserts a one-cycle bubble.

Parameters:
- PC_RESET, 0, reset value of o_pc.
- ALU_OP_W, 4, width of encoded ALU operation.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_pc  input  32  PC of incoming instruction
- i_instr  input  32  incoming instruction
- i_clk_en  input  1  incoming instruction valid (fetch clk_en)
- i_stall  input  1  whole-pipeline stall
- i_flush  input  1  flush this stage
- o_stall_req  output  1  load-use hazard; ORed into fetch stall only, never into i_stall
- o_clk_en  output  1  registered instruction valid for execute
- o_pc  output  32  registered PC
- o_rs1_addr  output  5  source register 1
- o_rs2_addr  output  5  source register 2
- o_rd_addr  output  5  destination register
- o_imm  output  32  sign-extended immediate
- o_funct3  output  3  instr[14:12]
- o_alu_op  output  ALU_OP_W  encoded ALU operation
- o_class  output  11  one-hot {fence,system,auipc,lui,jalr,jal,branch,store,load,itype,rtype} (bit 10..0)
- o_illegal  output  1  illegal instruction
- o_ecall, o_ebreak, o_mret  output  1 each  system decode

Behaviour:
- Reset (rst high at clk edge): o_clk_en=0, o_pc=PC_RESET, all other outputs 0. Reset overrides stall and flush.
- Latency: 1 cycle, i_* to o_*.
- Update priority each edge:
  1. i_stall=1: hold every register, including o_clk_en.
  2. i_flush=1: o_clk_en<=0; other fields hold.
  3. o_stall_req=1: o_clk_en<=0 (bubble); fields hold.
  4. Otherwise: o_clk_en<=i_clk_en. When i_clk_en=1, all fields load the decode of i_instr/i_pc; when 0, fields hold.
- Hazard (combinational): o_stall_req = o_clk_en & o_class[load] & (o_rd_addr!=0) & i_clk_en & ((uses_rs1 & rs1==o_rd_addr) | (uses_rs2 & rs2==o_rd_addr)).
  - uses_rs1: rtype, itype, load, store, branch, jalr.
  - uses_rs2: rtype, store, branch.
  - After the bubble, o_clk_en=0, so o_stall_req drops and the held instruction (fetch stalled) decodes next cycle. Exactly one bubble per load-use pair.
- Opcodes (instr[6:0]):
  - 0110011 rtype, 0010011 itype, 0000011 load, 0100011 store, 1100011 branch
  - 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc, 1110011 system, 0001111 fence.
- Immediates (sign bit instr[31]):
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - rtype: 0.
- ALU op encoding: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 EQ10 NE11 LT12 GE13 LTU14 GEU15.
  - rtype/itype: from funct3/funct7. SUB only for rtype funct7=0100000; SRA for funct7=0100000 with funct3=101.
  - Branch: funct3 000→EQ, 001→NE, 100→LT, 101→GE, 110→LTU, 111→GEU.
  - All other classes: ADD.
- Illegal when any of:
  - opcode not in the list above;
  - rtype funct7 not in {0000000,0100000}, or 0100000 with funct3 not in {000,101};
  - itype funct3=001 with funct7≠0, or funct3=101 with funct7 not in {0000000,0100000};
  - branch funct3 in {010,011};
  - load funct3 in {011,110,111};
  - store funct3>010;
  - jalr funct3≠0;
  - system with funct3=000 and instr not exactly ecall (0x00000073), ebreak (0x00100073) or mret (0x30200073).
- Illegal behaviour: o_class=0, o_alu_op=ADD, o_illegal=1, o_clk_en follows the normal rule. The exception is raised downstream.
- rs/rd addresses: always instr[19:15]/[24:20]/[11:7], regardless of class.

Test Plan:
- Reset, then i_clk_en=1, i_instr=0xFFF00093 (addi x1,x0,-1), i_pc=0x100 → next cycle o_clk_en=1, o_pc=0x100, o_imm=0xFFFFFFFF, o_rd_addr=1, o_class=itype, o_alu_op=0.
- i_instr=0x00112023 (sw x1,0(x2)) then 0xFE0008E3 (beq x0,x0,-16) → o_imm=0 with class store, then o_imm=0xFFFFFFF0 with o_alu_op=10.
- Load lw x5,0(x1) (0x0000A283) followed by add x6,x5,x5 (0x00528333) → o_stall_req=1 for one cycle, one bubble (o_clk_en=0), then the add is issued. Repeat with rd=x0 → no stall.
- i_stall=1 for 3 cycles with a new i_instr each cycle → outputs frozen. i_flush with i_stall=0 → o_clk_en=0 next cycle.
- i_instr=0x0000007F, 0x40001033 (invalid funct7 0100000 with funct3=001), 0x00100073 → o_illegal=1, o_illegal=1, o_ebreak=1.
- Assert rst mid-stream while i_stall=1 → all outputs return to reset values on that edge.
